// File: rtl/upsample_2x2.sv
// upsample_2x2: 2x2 nearest-neighbour upsampler (inverse of 2x2 max-pool).
// Each pooled pixel is emitted twice on the first output row of a pair.
// The pooled row is then replayed from a row buffer for the second output row.
// Optional build macro UPSAMPLE_ZERO_FILL_EN selects max-unpool style output:
// the pixel goes to the top-left position and every other position is zero.
module upsample_2x2 #(
  parameter int DATA_WIDTH = 32,
  parameter int IMG_WIDTH  = 32,
  parameter int IMG_HEIGHT = 32
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic [DATA_WIDTH-1:0] DATA_IN,
  input  logic                  data_valid_in,
  output logic                  ready_out,
  output logic [DATA_WIDTH-1:0] DATA_OUT,
  output logic                  data_valid_out,
  input  logic                  ready_in,
  output logic                  frame_done
);

  localparam int unsigned HALF_W = IMG_WIDTH / 2;
  localparam int unsigned HALF_H = IMG_HEIGHT / 2;
  localparam int unsigned CW     = (HALF_W > 1) ? $clog2(HALF_W) : 1;
  localparam int unsigned RW     = (HALF_H > 1) ? $clog2(HALF_H) : 1;
  localparam logic [CW-1:0] LAST_COL = CW'(HALF_W - 1);
  localparam logic [RW-1:0] LAST_ROW = RW'(HALF_H - 1);

  typedef enum logic {FILL, REPLAY} state_t;

  state_t                r_state, w_state_nxt;
  logic [DATA_WIDTH-1:0] r_dout;
  logic                  r_vld;
  logic                  r_dup;
  logic [CW-1:0]         r_col;
  logic [CW-1:0]         r_rd;
  logic [RW-1:0]         r_prow;

  logic                  w_in_fire, w_out_fire, w_ready, w_frame_end;
  logic                  w_last_col, w_last_rd, w_last_row;
  logic [CW-1:0]         w_rd_next;
  logic [DATA_WIDTH-1:0] w_replay_first, w_replay_next;

  assign w_out_fire = r_vld & ready_in;
  assign w_in_fire  = data_valid_in & ready_out;
  assign w_last_col = (r_col == LAST_COL);
  assign w_last_rd  = (r_rd == LAST_COL);
  assign w_last_row = (r_prow == LAST_ROW);
  assign w_rd_next  = r_rd + CW'(1);

  assign ready_out      = RST_N & w_ready;
  assign frame_done     = RST_N & w_frame_end;
  assign DATA_OUT       = r_dout;
  assign data_valid_out = r_vld;

`ifdef UPSAMPLE_ZERO_FILL_EN
  assign w_replay_first = '0;
  assign w_replay_next  = '0;
`else
  logic [DATA_WIDTH-1:0] r_rowbuf [HALF_W];
  logic [CW-1:0]         w_wr_idx;

  // A pixel accepted together with the previous pixel's second copy belongs to the next column.
  assign w_wr_idx = (w_out_fire & r_dup) ? (r_col + CW'(1)) : r_col;

  // Capture each accepted pooled pixel for the replay row.
  always_ff @(posedge CLK) begin
    if (w_in_fire) r_rowbuf[w_wr_idx] <= DATA_IN;
  end

  assign w_replay_first = r_rowbuf[0];
  assign w_replay_next  = r_rowbuf[w_rd_next];
`endif

  // State register.
  always_ff @(posedge CLK) begin
    if (!RST_N) r_state <= FILL;
    else        r_state <= w_state_nxt;
  end

  // Next state, input ready and end-of-frame strobe.
  always_comb begin
    w_state_nxt = r_state;
    w_ready     = 1'b0;
    w_frame_end = 1'b0;
    case (r_state)
      FILL: begin
        w_ready = !r_vld | (w_out_fire & r_dup & !w_last_col);
        if (w_out_fire & r_dup & w_last_col) w_state_nxt = REPLAY;
      end
      REPLAY: begin
        if (w_out_fire & r_dup & w_last_rd) begin
          w_state_nxt = FILL;
          w_frame_end = w_last_row;
        end
      end
      default: w_state_nxt = FILL;
    endcase
  end

  // Output register, copy flag and column/replay/row-pair counters.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_dout <= '0;
      r_vld  <= 1'b0;
      r_dup  <= 1'b0;
      r_col  <= '0;
      r_rd   <= '0;
      r_prow <= '0;
    end else begin
      case (r_state)
        FILL: begin
          if (w_in_fire) begin
            r_dout <= DATA_IN;
            r_vld  <= 1'b1;
            r_dup  <= 1'b0;
            if (w_out_fire & r_dup) r_col <= r_col + CW'(1);
          end else if (w_out_fire) begin
            if (!r_dup) begin
              r_dup <= 1'b1;
`ifdef UPSAMPLE_ZERO_FILL_EN
              r_dout <= '0;
`endif
            end else if (w_last_col) begin
              // Preload the first replay pixel so the second row follows without a bubble.
              r_col  <= '0;
              r_rd   <= '0;
              r_dup  <= 1'b0;
              r_dout <= w_replay_first;
            end else begin
              r_vld <= 1'b0;
              r_dup <= 1'b0;
              r_col <= r_col + CW'(1);
            end
          end
        end
        REPLAY: begin
          if (w_out_fire) begin
            if (!r_dup) begin
              r_dup <= 1'b1;
            end else if (w_last_rd) begin
              r_vld  <= 1'b0;
              r_dup  <= 1'b0;
              r_rd   <= '0;
              r_prow <= w_last_row ? '0 : (r_prow + RW'(1));
            end else begin
              r_rd   <= w_rd_next;
              r_dup  <= 1'b0;
              r_dout <= w_replay_next;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_upsample_2x2.sv
// Bench for upsample_2x2 at IMG_WIDTH=4, IMG_HEIGHT=4, DATA_WIDTH=32.
// Inputs are driven 1 time unit after the rising edge; DUT outputs are sampled
// 2 units after the falling edge. Accepted inputs feed a reference model that
// pushes the expected output pixels into a scoreboard queue.
module tb_upsample_2x2;

  localparam int DW = 32;
  localparam int W  = 4;
  localparam int H  = 4;

  logic          CLK = 1'b0;
  logic          RST_N;
  logic [DW-1:0] DATA_IN;
  logic          data_valid_in;
  logic          ready_out;
  logic [DW-1:0] DATA_OUT;
  logic          data_valid_out;
  logic          ready_in;
  logic          frame_done;

  upsample_2x2 #(.DATA_WIDTH(DW), .IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .CLK(CLK), .RST_N(RST_N), .DATA_IN(DATA_IN), .data_valid_in(data_valid_in),
    .ready_out(ready_out), .DATA_OUT(DATA_OUT), .data_valid_out(data_valid_out),
    .ready_in(ready_in), .frame_done(frame_done)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [DW-1:0] data;
    logic          fd;
  } exp_t;

  typedef struct {
    logic [DW-1:0] data;
    int unsigned   gap;
    int            exp_wait;
  } vec_t;

  exp_t          sb[$];
  logic [DW-1:0] mrow[$];
  logic [DW-1:0] olog[$];
  int            mprow = 0;
  int            errors = 0;
  int            checks = 0;
  int            fd_count = 0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    sb.delete();
    mrow.delete();
    mprow = 0;
  endtask

  // Reference model: first row of the pair repeats each pixel, second row replays the whole row.
  task automatic model_accept(input logic [DW-1:0] p);
    exp_t e;
    logic [DW-1:0] v;
    e.fd = 1'b0;
    e.data = p;
    sb.push_back(e);
`ifdef UPSAMPLE_ZERO_FILL_EN
    e.data = '0;
`endif
    sb.push_back(e);
    mrow.push_back(p);
    if (mrow.size() == W / 2) begin
      for (int i = 0; i < W / 2; i++) begin
`ifdef UPSAMPLE_ZERO_FILL_EN
        v = '0;
`else
        v = mrow[i];
`endif
        e.data = v;
        e.fd   = 1'b0;
        sb.push_back(e);
        e.fd   = (i == W / 2 - 1) && (mprow == H / 2 - 1);
        sb.push_back(e);
      end
      mprow = (mprow + 1) % (H / 2);
      mrow.delete();
    end
  endtask

  // Output monitor / scoreboard.
  always @(negedge CLK) begin
    exp_t e;
    #2;
    if (RST_N === 1'b1) begin
      if (data_valid_out && ready_in) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_out: got %0h expected no output at %0t", DATA_OUT, $time);
        end else begin
          e = sb.pop_front();
          chk("out_data", DATA_OUT, e.data);
          chk("out_frame_done", {31'd0, frame_done}, {31'd0, e.fd});
          olog.push_back(DATA_OUT);
          if (frame_done) fd_count++;
        end
      end else begin
        chk("frame_done_idle", {31'd0, frame_done}, '0);
      end
      if (data_valid_in && ready_out) model_accept(DATA_IN);
    end
  end

  // Offer one pixel after 'gap' idle cycles; report how many cycles it waited for ready_out.
  task automatic send(input logic [DW-1:0] d, input int unsigned gap, output int waits);
    data_valid_in = 1'b0;
    for (int unsigned g = 0; g < gap; g++) begin
      @(negedge CLK);
      #2;
      if (g == gap - 1 && gap >= 3) begin
        chk("gap_ready_out", {31'd0, ready_out}, 32'd1);
        chk("gap_valid_out", {31'd0, data_valid_out}, '0);
      end
      @(posedge CLK);
      #1;
    end
    DATA_IN = d;
    data_valid_in = 1'b1;
    waits = 0;
    while (1) begin
      @(negedge CLK);
      #2;
      if (ready_out) break;
      waits++;
      if (waits > 50) begin
        checks++;
        errors++;
        $display("FAIL accept_timeout: got no ready_out expected accept of %0h", d);
        break;
      end
    end
    @(posedge CLK);
    #1;
    data_valid_in = 1'b0;
  endtask

  vec_t          vt[12];
  logic [DW-1:0] exp1[16];

  initial begin
    int  w;
    bit  seen;
    vt[0]  = '{data: 32'd1,  gap: 0, exp_wait: 0};
    vt[1]  = '{data: 32'd2,  gap: 0, exp_wait: 1};
    vt[2]  = '{data: 32'd3,  gap: 0, exp_wait: 6};
    vt[3]  = '{data: 32'd4,  gap: 0, exp_wait: 1};
    vt[4]  = '{data: 32'd10, gap: 0, exp_wait: 6};
    vt[5]  = '{data: 32'd20, gap: 5, exp_wait: 0};
    vt[6]  = '{data: 32'd30, gap: 0, exp_wait: 6};
    vt[7]  = '{data: 32'd40, gap: 0, exp_wait: 1};
    vt[8]  = '{data: 32'd5,  gap: 0, exp_wait: 0};
    vt[9]  = '{data: 32'd6,  gap: 0, exp_wait: 1};
    vt[10] = '{data: 32'd7,  gap: 0, exp_wait: 6};
    vt[11] = '{data: 32'd8,  gap: 0, exp_wait: 1};
`ifdef UPSAMPLE_ZERO_FILL_EN
    exp1 = '{1, 0, 2, 0, 0, 0, 0, 0, 3, 0, 4, 0, 0, 0, 0, 0};
`else
    exp1 = '{1, 1, 2, 2, 1, 1, 2, 2, 3, 3, 4, 4, 3, 3, 4, 4};
`endif

    RST_N = 1'b0;
    ready_in = 1'b1;
    data_valid_in = 1'b0;
    DATA_IN = '0;
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_ready_out", {31'd0, ready_out}, '0);
    chk("rst_valid_out", {31'd0, data_valid_out}, '0);
    chk("rst_data_out", DATA_OUT, '0);
    chk("rst_frame_done", {31'd0, frame_done}, '0);
    RST_N = 1'b1;
    #1;
    chk("post_rst_ready_out", {31'd0, ready_out}, 32'd1);

    // Two frames from the table: continuous input, replay stall, input gap.
    for (int i = 0; i < 8; i++) begin
      send(vt[i].data, vt[i].gap, w);
      chk($sformatf("accept_wait[%0d]", i), w, vt[i].exp_wait);
    end

    // Downstream stall on the first copy of pixel 2.
    fork
      begin
        for (int i = 1; i <= 4; i++) send(i, 0, w);
      end
      begin
        seen = 0;
        for (int i = 0; i < 200; i++) begin
          @(negedge CLK);
          if (data_valid_out && DATA_OUT == 2) begin
            seen = 1;
            break;
          end
        end
        if (!seen) begin
          checks++;
          errors++;
          $display("FAIL stall_trigger: got no pixel 2 expected pixel 2 on output");
        end
        ready_in = 1'b0;
        for (int k = 0; k < 3; k++) begin
          #2;
          chk("stall_valid_held", {31'd0, data_valid_out}, 32'd1);
          chk("stall_data_held", DATA_OUT, 32'd2);
          @(negedge CLK);
        end
        ready_in = 1'b1;
      end
    join

    // Reset during the replay row: everything in flight is discarded.
    send(32'd1, 0, w);
    send(32'd2, 0, w);
    repeat (2) @(posedge CLK);
    #1;
    chk("replay_valid_before_rst", {31'd0, data_valid_out}, 32'd1);
    chk("replay_ready_out", {31'd0, ready_out}, '0);
    RST_N = 1'b0;
    model_reset();
    @(posedge CLK);
    #1;
    chk("midrst_valid_out", {31'd0, data_valid_out}, '0);
    chk("midrst_data_out", DATA_OUT, '0);
    RST_N = 1'b1;
    #1;
    chk("midrst_ready_out", {31'd0, ready_out}, 32'd1);
    for (int i = 8; i < 12; i++) begin
      send(vt[i].data, vt[i].gap, w);
      chk($sformatf("accept_wait[%0d]", i), w, vt[i].exp_wait);
    end

    for (int i = 0; i < 100 && sb.size() != 0; i++) @(posedge CLK);
    repeat (2) @(posedge CLK);
    chk("scoreboard_drained", sb.size(), '0);
    chk("frame_done_count", fd_count, 32'd4);
    for (int i = 0; i < 16; i++) begin
      if (i < olog.size()) chk($sformatf("frame1_seq[%0d]", i), olog[i], exp1[i]);
      else chk($sformatf("frame1_seq_len[%0d]", i), olog.size(), 32'd16);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
